// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and constants for the memory-stage controller.
//   state_e                 : controller state (IDLE, WAIT)
//   WORD_W / REG_W          : datapath and register-index widths
//   DEFAULT_TIMEOUT_CYCLES  : default watchdog limit (MEM_TIMEOUT_EN builds)
//   DEFAULT_CNT_W           : default wait-counter width
package mem_stage_pkg;

    localparam int WORD_W                 = 16;
    localparam int REG_W                  = 3;
    localparam int DEFAULT_TIMEOUT_CYCLES = 255;
    localparam int DEFAULT_CNT_W          = 8;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if: request/response bus between the memory-stage controller
// and the multi-cycle data memory.
//   master (controller) : drives mem_en, mem_wr, mem_addr, mem_wdata;
//                         receives mem_rdata, mem_stall, mem_done
//   slave  (memory)     : the reverse
interface mem_stage_ctrl_if;
    import mem_stage_pkg::*;

    logic              mem_en;
    logic              mem_wr;
    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;
    logic              mem_stall;
    logic              mem_done;

    modport master (
        output mem_en, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata, mem_stall, mem_done
    );

    modport slave (
        input  mem_en, mem_wr, mem_addr, mem_wdata,
        output mem_rdata, mem_stall, mem_done
    );

endinterface

// File: rtl/mem_stage_watchdog.sv
// mem_stage_watchdog: saturating wait-cycle counter with timeout compare.
// Only instantiated when MEM_TIMEOUT_EN is defined.
//   clk, rst   : clock, synchronous active-high reset
//   en_i       : count this cycle (controller is in WAIT)
//   clr_i      : restart from zero (controller is leaving IDLE for WAIT)
//   expired_o  : counter has reached TIMEOUT_CYCLES
module mem_stage_watchdog #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic expired_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == CNT_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage controller between X/M and M/W. Issues loads and
// stores to a multi-cycle data memory, bubbles M/W and freezes upstream stages
// while an access is outstanding, and forwards X/M fields to M/W on completion.
// Build option: MEM_TIMEOUT_EN adds a WAIT watchdog with a sticky err flag.
//   clk, rst             : clock, synchronous active-high reset
//   valid_in .. halt_in  : X/M instruction and control fields
//   mem (master)         : data-memory request/response bus
//   *_out                : M/W fields
//   stall_out            : freeze PC, F/D, D/X, X/M this cycle
//   err                  : sticky memory-timeout error (0 without MEM_TIMEOUT_EN)
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no access outstanding; retry stalled requests, pass others through
// WAIT  | request accepted, waiting for mem_done; upstream frozen, M/W bubbled
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic [WORD_W-1:0] addr_in,
    input  logic [WORD_W-1:0] wdata_in,
    input  logic              Jump_in,
    input  logic              MemToReg_in,
    input  logic              RegWrite_in,
    input  logic              halt_in,
    input  logic [WORD_W-1:0] pc_in,
    input  logic [REG_W-1:0]  writereg_in,
    mem_stage_ctrl_if.master  mem,
    output logic              Jump_out,
    output logic              MemToReg_out,
    output logic              RegWrite_out,
    output logic              halt_out,
    output logic [WORD_W-1:0] pc_out,
    output logic [WORD_W-1:0] alu_out_out,
    output logic [WORD_W-1:0] mem_out_out,
    output logic [REG_W-1:0]  writereg_out,
    output logic              stall_out,
    output logic              err
);

    if ((CNT_W < 1) || (CNT_W > 30) || ((1 << CNT_W) <= TIMEOUT_CYCLES)) begin : g_bad_cfg
        $error("mem_stage_ctrl: CNT_W too narrow for TIMEOUT_CYCLES");
    end

    state_e state_q, state_d;
    logic   mem_op;
    logic   pass;          // 1 = forward X/M fields, 0 = bubble
    logic   timeout_fire;
    logic   wd_expired;

`ifdef MEM_TIMEOUT_EN
    logic err_q, err_d;
    logic wd_clr;

    assign wd_clr = (state_q == IDLE) && (state_d == WAIT);

    mem_stage_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .en_i      (state_q == WAIT),
        .clr_i     (wd_clr),
        .expired_o (wd_expired)
    );

    always_comb begin
        err_d = err_q | timeout_fire;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign wd_expired = 1'b0;
    assign err        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Address, data and direction follow X/M permanently; mem_en alone qualifies them.
    assign mem.mem_addr  = addr_in;
    assign mem.mem_wdata = wdata_in;
    assign mem.mem_wr    = MemWrite_in;

    assign mem_op = valid_in & (MemRead_in | MemWrite_in) & ~halt_in;

    always_comb begin
        state_d      = state_q;
        mem.mem_en   = 1'b0;
        stall_out    = 1'b0;
        pass         = 1'b1;
        timeout_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    mem.mem_en = 1'b1;
                    if (mem.mem_stall) begin
                        stall_out = 1'b1;
                        pass      = 1'b0;
                    end else if (!mem.mem_done) begin
                        stall_out = 1'b1;
                        pass      = 1'b0;
                        state_d   = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem.mem_done) begin
                    state_d = IDLE;
                end else if (wd_expired) begin
                    timeout_fire = 1'b1;
                    state_d      = IDLE;
                end else begin
                    stall_out = 1'b1;
                    pass      = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (rst) begin
            mem.mem_en = 1'b0;
            stall_out  = 1'b0;
            state_d    = IDLE;
        end
    end

    always_comb begin
        Jump_out     = pass & Jump_in;
        MemToReg_out = pass & MemToReg_in;
        RegWrite_out = pass & valid_in & RegWrite_in & ~timeout_fire & ~rst;
        // A timeout is reported downstream as a halt so the pipeline stops cleanly.
        halt_out     = ((pass & valid_in & halt_in) | timeout_fire) & ~rst;
        pc_out       = pc_in;
        alu_out_out  = addr_in;
        mem_out_out  = mem.mem_rdata;
        writereg_out = writereg_in;
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;
    import mem_stage_pkg::*;

    localparam int TB_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, MemRead_in, MemWrite_in, Jump_in, MemToReg_in, RegWrite_in, halt_in;
    logic [15:0] addr_in, wdata_in, pc_in;
    logic [2:0]  writereg_in;
    logic        Jump_out, MemToReg_out, RegWrite_out, halt_out, stall_out, err;
    logic [15:0] pc_out, alu_out_out, mem_out_out;
    logic [2:0]  writereg_out;

    int n_vec = 0;
    int n_err = 0;

    mem_stage_ctrl_if mif ();

    mem_stage_ctrl #(
        .TIMEOUT_CYCLES (TB_TIMEOUT),
        .CNT_W          (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .MemRead_in   (MemRead_in),
        .MemWrite_in  (MemWrite_in),
        .addr_in      (addr_in),
        .wdata_in     (wdata_in),
        .Jump_in      (Jump_in),
        .MemToReg_in  (MemToReg_in),
        .RegWrite_in  (RegWrite_in),
        .halt_in      (halt_in),
        .pc_in        (pc_in),
        .writereg_in  (writereg_in),
        .mem          (mif),
        .Jump_out     (Jump_out),
        .MemToReg_out (MemToReg_out),
        .RegWrite_out (RegWrite_out),
        .halt_out     (halt_out),
        .pc_out       (pc_out),
        .alu_out_out  (alu_out_out),
        .mem_out_out  (mem_out_out),
        .writereg_out (writereg_out),
        .stall_out    (stall_out),
        .err          (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic drive_idle();
        valid_in = 0; MemRead_in = 0; MemWrite_in = 0; Jump_in = 0; MemToReg_in = 0;
        RegWrite_in = 0; halt_in = 0; addr_in = 0; wdata_in = 0; pc_in = 0; writereg_in = 0;
        mif.mem_stall = 0; mif.mem_done = 0; mif.mem_rdata = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1;
        valid_in = 1; MemRead_in = 1; RegWrite_in = 1; addr_in = 16'h0010;
        next_cycle();
        #4;
        n_vec++; if (mif.mem_en !== 1'b0) begin n_err++; $display("FAIL reset_mem_en got %b exp 0", mif.mem_en); end
        n_vec++; if (stall_out !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b exp 0", stall_out); end
        n_vec++; if (RegWrite_out !== 1'b0) begin n_err++; $display("FAIL reset_regwrite got %b exp 0", RegWrite_out); end
        MemRead_in = 0; halt_in = 1;
        #1;
        n_vec++; if (halt_out !== 1'b0) begin n_err++; $display("FAIL reset_halt got %b exp 0", halt_out); end
        next_cycle();
        rst = 0;
        drive_idle();
        #4;
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b exp 0", err); end
        n_vec++; if (stall_out !== 1'b0) begin n_err++; $display("FAIL post_reset_stall got %b exp 0", stall_out); end
        next_cycle();
    endtask

    // Timeline model of one X/M instruction: a memory op is retried for s cycles
    // under mem_stall, accepted on cycle s, and completes l cycles later (cycle s+l).
    // Every cycle before completion is a bubble with stall_out=1.
    task automatic test_instr(input bit v, input bit rd, input bit wr, input bit j,
                              input bit mtr, input bit rw, input bit hlt,
                              input int s, input int l, input logic [15:0] a,
                              input logic [15:0] wd, input logic [15:0] pc,
                              input logic [2:0] wreg, input logic [15:0] rd_val,
                              input string name);
        bit is_mem = v & (rd | wr) & ~hlt;
        int ncyc   = is_mem ? (s + l + 1) : 1;
        int n_en   = 0;
        valid_in = v; MemRead_in = rd; MemWrite_in = wr; Jump_in = j; MemToReg_in = mtr;
        RegWrite_in = rw; halt_in = hlt; addr_in = a; wdata_in = wd; pc_in = pc; writereg_in = wreg;
        for (int c = 0; c < ncyc; c++) begin
            bit          e_en, e_st, pas;
            logic [15:0] rdata;
            rdata = (c == ncyc - 1) ? rd_val : 16'($urandom);
            mif.mem_rdata = rdata;
            if (is_mem) begin
                mif.mem_stall = (c < s) ? 1'b1 : ((c == s) ? 1'b0 : 1'($urandom));
                mif.mem_done  = (c == s + l);
            end else begin
                mif.mem_stall = 1'($urandom);
                mif.mem_done  = 1'($urandom);
            end
            e_en = is_mem && (c <= s);
            e_st = is_mem && (c < ncyc - 1);
            pas  = !e_st;
            #4;
            if (mif.mem_en === 1'b1) n_en++;
            n_vec++; if (mif.mem_en !== e_en) begin n_err++; $display("FAIL %s c%0d mem_en got %b exp %b", name, c, mif.mem_en, e_en); end
            n_vec++; if (stall_out !== e_st) begin n_err++; $display("FAIL %s c%0d stall_out got %b exp %b", name, c, stall_out, e_st); end
            n_vec++; if (RegWrite_out !== (pas & v & rw)) begin n_err++; $display("FAIL %s c%0d RegWrite_out got %b exp %b", name, c, RegWrite_out, pas & v & rw); end
            n_vec++; if (halt_out !== (pas & v & hlt)) begin n_err++; $display("FAIL %s c%0d halt_out got %b exp %b", name, c, halt_out, pas & v & hlt); end
            n_vec++; if (Jump_out !== (pas & j)) begin n_err++; $display("FAIL %s c%0d Jump_out got %b exp %b", name, c, Jump_out, pas & j); end
            n_vec++; if (MemToReg_out !== (pas & mtr)) begin n_err++; $display("FAIL %s c%0d MemToReg_out got %b exp %b", name, c, MemToReg_out, pas & mtr); end
            n_vec++; if (mif.mem_addr !== a) begin n_err++; $display("FAIL %s c%0d mem_addr got %h exp %h", name, c, mif.mem_addr, a); end
            n_vec++; if (mif.mem_wdata !== wd) begin n_err++; $display("FAIL %s c%0d mem_wdata got %h exp %h", name, c, mif.mem_wdata, wd); end
            n_vec++; if (mif.mem_wr !== wr) begin n_err++; $display("FAIL %s c%0d mem_wr got %b exp %b", name, c, mif.mem_wr, wr); end
            if (pas) begin
                n_vec++; if (alu_out_out !== a) begin n_err++; $display("FAIL %s c%0d alu_out got %h exp %h", name, c, alu_out_out, a); end
                n_vec++; if (pc_out !== pc) begin n_err++; $display("FAIL %s c%0d pc_out got %h exp %h", name, c, pc_out, pc); end
                n_vec++; if (writereg_out !== wreg) begin n_err++; $display("FAIL %s c%0d writereg got %0d exp %0d", name, c, writereg_out, wreg); end
                if (is_mem && rd) begin
                    n_vec++; if (mem_out_out !== rd_val) begin n_err++; $display("FAIL %s c%0d mem_out got %h exp %h", name, c, mem_out_out, rd_val); end
                end
            end
            next_cycle();
        end
        n_vec++; if (n_en !== (is_mem ? s + 1 : 0)) begin n_err++; $display("FAIL %s mem_en_count got %0d exp %0d", name, n_en, is_mem ? s + 1 : 0); end
        drive_idle();
    endtask

    task automatic test_rst_mid_wait();
        drive_idle();
        valid_in = 1; MemRead_in = 1; RegWrite_in = 1; addr_in = 16'h0200;
        #4;
        n_vec++; if (mif.mem_en !== 1'b1) begin n_err++; $display("FAIL rstwait_accept mem_en got %b exp 1", mif.mem_en); end
        next_cycle();
        #4;
        n_vec++; if (stall_out !== 1'b1) begin n_err++; $display("FAIL rstwait_wait stall got %b exp 1", stall_out); end
        next_cycle();
        rst = 1;
        #4;
        n_vec++; if (stall_out !== 1'b0) begin n_err++; $display("FAIL rstwait_rst stall got %b exp 0", stall_out); end
        n_vec++; if (RegWrite_out !== 1'b0) begin n_err++; $display("FAIL rstwait_rst regwrite got %b exp 0", RegWrite_out); end
        next_cycle();
        rst = 0;
        drive_idle();
        #4;
        n_vec++; if (stall_out !== 1'b0) begin n_err++; $display("FAIL rstwait_idle stall got %b exp 0", stall_out); end
        next_cycle();
        mif.mem_done = 1; mif.mem_rdata = 16'hDEAD;
        #4;
        n_vec++; if (stall_out !== 1'b0) begin n_err++; $display("FAIL rstwait_stale stall got %b exp 0", stall_out); end
        n_vec++; if (RegWrite_out !== 1'b0) begin n_err++; $display("FAIL rstwait_stale regwrite got %b exp 0", RegWrite_out); end
        n_vec++; if (mif.mem_en !== 1'b0) begin n_err++; $display("FAIL rstwait_stale mem_en got %b exp 0", mif.mem_en); end
        next_cycle();
        drive_idle();
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        drive_idle();
        valid_in = 1; MemRead_in = 1; RegWrite_in = 1; addr_in = 16'h0300;
        for (int c = 0; c <= TB_TIMEOUT + 1; c++) begin
            bit fire = (c == TB_TIMEOUT + 1);
            #4;
            n_vec++; if (stall_out !== !fire) begin n_err++; $display("FAIL timeout c%0d stall got %b exp %b", c, stall_out, !fire); end
            n_vec++; if (halt_out !== fire) begin n_err++; $display("FAIL timeout c%0d halt got %b exp %b", c, halt_out, fire); end
            n_vec++; if (RegWrite_out !== 1'b0) begin n_err++; $display("FAIL timeout c%0d regwrite got %b exp 0", c, RegWrite_out); end
            n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL timeout c%0d err got %b exp 0", c, err); end
            n_vec++; if (mif.mem_en !== (c == 0)) begin n_err++; $display("FAIL timeout c%0d mem_en got %b exp %b", c, mif.mem_en, c == 0); end
            next_cycle();
        end
        drive_idle();
        valid_in = 1; RegWrite_in = 1;
        for (int c = 0; c < 3; c++) begin
            #4;
            n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL timeout_sticky c%0d err got %b exp 1", c, err); end
            n_vec++; if (halt_out !== 1'b0) begin n_err++; $display("FAIL timeout_after c%0d halt got %b exp 0", c, halt_out); end
            next_cycle();
        end
        rst = 1;
        next_cycle();
        rst = 0;
        drive_idle();
        #4;
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL timeout_clear err got %b exp 0", err); end
        next_cycle();
    endtask
`else
    task automatic test_long_wait();
        drive_idle();
        valid_in = 1; MemRead_in = 1; RegWrite_in = 1; addr_in = 16'h0300;
        for (int c = 0; c <= 13; c++) begin
            bit done = (c == 13);
            mif.mem_done  = done;
            mif.mem_rdata = 16'hA5A5;
            #4;
            n_vec++; if (stall_out !== !done) begin n_err++; $display("FAIL longwait c%0d stall got %b exp %b", c, stall_out, !done); end
            n_vec++; if (mif.mem_en !== (c == 0)) begin n_err++; $display("FAIL longwait c%0d mem_en got %b exp %b", c, mif.mem_en, c == 0); end
            n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL longwait c%0d err got %b exp 0", c, err); end
            n_vec++; if (halt_out !== 1'b0) begin n_err++; $display("FAIL longwait c%0d halt got %b exp 0", c, halt_out); end
            if (done) begin
                n_vec++; if (mem_out_out !== 16'hA5A5) begin n_err++; $display("FAIL longwait mem_out got %h exp a5a5", mem_out_out); end
                n_vec++; if (RegWrite_out !== 1'b1) begin n_err++; $display("FAIL longwait regwrite got %b exp 1", RegWrite_out); end
            end
            next_cycle();
        end
        drive_idle();
    endtask
`endif

    initial begin
        test_reset();
        test_instr(1, 0, 0, 0, 0, 1, 0, 0, 0, 16'h1234, 16'h0000, 16'h0102, 3'd3, 16'h0000, "add");
        test_instr(1, 1, 0, 0, 1, 1, 0, 0, 0, 16'h0040, 16'h0000, 16'h0104, 3'd2, 16'hBEEF, "load_hit");
        test_instr(1, 1, 0, 0, 1, 1, 0, 0, 3, 16'h0042, 16'h0000, 16'h0106, 3'd4, 16'hC0DE, "load_wait3");
        test_instr(1, 0, 1, 0, 0, 0, 0, 2, 1, 16'h0044, 16'h5A5A, 16'h0108, 3'd0, 16'h0000, "store_stall2");
        test_instr(1, 1, 0, 0, 0, 0, 1, 0, 0, 16'h0046, 16'h0000, 16'h010A, 3'd0, 16'h0000, "halt");
        test_instr(0, 1, 0, 1, 1, 1, 0, 0, 0, 16'h0048, 16'h0000, 16'h010C, 3'd5, 16'h0000, "invalid_load");
        test_rst_mid_wait();
        test_instr(1, 1, 0, 0, 1, 1, 0, 0, 2, 16'h0050, 16'h0000, 16'h0110, 3'd6, 16'h1357, "load_after_rst");
        for (int i = 0; i < 60; i++) begin
            int k  = int'($urandom_range(0, 5));
            bit v  = ($urandom_range(0, 7) != 0);
            bit rd = (k == 1) || (k == 2);
            bit wr = (k == 3);
            bit ht = (k == 5);
            test_instr(v, rd, wr, 1'($urandom), 1'($urandom), 1'($urandom), ht,
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                       16'($urandom), 16'($urandom), 16'($urandom), 3'($urandom),
                       16'($urandom), "random");
        end
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-stage controller of the 5-stage pipeline; sits between the X/M pipeline register and the M/W pipeline register.
- Issues loads and stores to a multi-cycle data memory (stall/done handshake).
- Inserts bubbles into M/W and freezes upstream stages while an access is outstanding.
- Forwards control and data fields to M/W unchanged on completion.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles in WAIT before watchdog fires (MEM_TIMEOUT_EN only).
- CNT_W, 8, width of the wait-cycle counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid_in  in  1  X/M holds a real instruction
- MemRead_in  in  1  load
- MemWrite_in  in  1  store
- addr_in  in  16  memory address (ALU result)
- wdata_in  in  16  store data
- Jump_in, MemToReg_in, RegWrite_in, halt_in  in  1 each  control from X/M
- pc_in  in  16  PC+2 from X/M
- writereg_in  in  3  destination register
- mem_en  out  1  memory request strobe
- mem_wr  out  1  1=write, 0=read
- mem_addr  out  16  request address
- mem_wdata  out  16  request write data
- mem_rdata  in  16  read data, valid when mem_done=1
- mem_stall  in  1  memory cannot accept request this cycle
- mem_done  in  1  access complete (single-cycle pulse)
- Jump_out, MemToReg_out, RegWrite_out, halt_out  out  1 each  to M/W
- pc_out, alu_out_out, mem_out_out  out  16 each  to M/W
- writereg_out  out  3  to M/W
- stall_out  out  1  freeze PC, F/D, D/X, X/M this cycle
- err  out  1  sticky memory-timeout error

Behaviour:
- Clock and reset:
  - Clock `clk`; reset `rst` is synchronous and active-high. One clock domain.
  - On reset: state=IDLE, wait counter=0, err=0.
  - Every output is combinational from state plus inputs. While rst=1: mem_en=0, stall_out=0, RegWrite_out=0, halt_out=0.
- Memory op: mem_op = valid_in & (MemRead_in | MemWrite_in) & ~halt_in.
- Bubble: RegWrite_out=0, halt_out=0, Jump_out=0, MemToReg_out=0. Data outputs are don't-care.
- Pass-through: all *_out = matching *_in, alu_out_out=addr_in, mem_out_out=mem_rdata.
  - RegWrite_out and halt_out are gated by valid_in.
- mem_addr=addr_in, mem_wdata=wdata_in, mem_wr=MemWrite_in at all times. Only mem_en qualifies them.
- State IDLE:
  - No mem_op: pass-through, stall_out=0, stay IDLE. mem_done is ignored, including stale responses after reset.
  - mem_op and mem_stall=1: mem_en=1, stall_out=1, bubble, stay IDLE. The request is retried every cycle.
  - mem_op, mem_stall=0, mem_done=1 (zero-wait hit): mem_en=1, pass-through, stall_out=0, stay IDLE. Latency 0 extra cycles.
  - mem_op, mem_stall=0, mem_done=0: mem_en=1, stall_out=1, bubble, next=WAIT, counter cleared.
- State WAIT:
  - mem_en=0. Upstream inputs are held stable by stall_out.
  - mem_done=0: stall_out=1, bubble, counter increments, saturating at all-ones.
  - mem_done=1: pass-through with mem_rdata, stall_out=0, next=IDLE.
  - Load latency to M/W = N stall cycles, where done arrives N cycles after acceptance.
- Stores complete identically. mem_out_out is don't-care; RegWrite follows RegWrite_in, normally 0.
- halt_in with valid_in never touches memory; it is passed through in IDLE.
- Exactly one mem_en per accepted request. mem_en is never asserted in WAIT.
- Reset mid-WAIT abandons the access. The next instruction reissues from IDLE.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - In WAIT, when counter reaches TIMEOUT_CYCLES with no mem_done, set err=1 (sticky until rst).
  - Emit a pass-through with halt_out=1 and RegWrite_out=0. Drop stall_out, go IDLE.
- Undefined:
  - err tied to 0; WAIT persists indefinitely.
  - Counter logic may be removed.

Decomposition:
- Package mem_stage_pkg:
  - state typedef {IDLE, WAIT}.
  - Default TIMEOUT_CYCLES constant.
  - Width constants: WORD_W=16, REG_W=3.
- Sub-module mem_stage_watchdog holds the counter, saturation and compare. Enable = in WAIT, clear = leaving IDLE.
  - Instantiated only under MEM_TIMEOUT_EN.

Test Plan:
- Non-memory ADD: valid_in=1, RegWrite_in=1, writereg_in=3, addr_in=0x1234 -> same cycle alu_out_out=0x1234, RegWrite_out=1, writereg_out=3, stall_out=0, mem_en=0.
- Load, done at acceptance: MemRead_in=1, addr_in=0x0040, mem_rdata=0xBEEF with done -> mem_en=1 for one cycle, mem_out_out=0xBEEF, stall_out=0.
- Load, done 3 cycles after acceptance: stall_out=1 for exactly 3 cycles with RegWrite_out=0 -> then pass-through with rdata, mem_en asserted only once.
- Store under mem_stall=1 for 2 cycles: mem_en=1, mem_wr=1 on 3 consecutive cycles; accepted on the 3rd; done 1 cycle later -> total 3 bubble cycles.
- rst asserted in WAIT, stale mem_done the next cycle -> state IDLE, no pass-through of stale data, stall_out=0.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4 and no done -> err=1 after 4 WAIT cycles, halt_out=1 for one cycle, err stays 1 until rst.
